time_field_counter: RTL and testbench



---
 rtl/clock_pkg.sv | 21 ++
 rtl/button_repeat.sv | 108 ++++++++++
 rtl/time_field_counter.sv | 85 ++++++++
 tb/tb_time_field_counter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and field limits for the clock/calendar counters.
// Holds the button FSM state encoding and a range-check helper used on loads.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    localparam int HOURS_MAX  = 23;
    localparam int MINSEC_MAX = 59;
    localparam int DAY_MIN    = 1;
    localparam int DAY_MAX    = 31;

    // Signed int compare keeps a MIN of 0 from turning into a constant test
    function automatic logic in_range(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/button_repeat.sv
// Purpose: edge-detect two adjust buttons, emit one step per press plus hold-to-auto-repeat.
// Latency: first step is combinational on the rising sample; repeat steps follow the hold/repeat timer.
// Backpressure: none; clear (load) or both buttons high forces IDLE and drops any pending step.
module button_repeat
    import clock_pkg::*;
#(
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_dn,
    input  logic clear,
    output logic step_up,
    output logic step_dn,
    output logic editing
);

    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

    btn_state_t    state;
    logic [TW-1:0] timer;
    logic          dir_up;
    logic          prev_up;
    logic          prev_dn;

    logic rise_up;
    logic rise_dn;
    logic held;
    logic fire;

    // A press only counts when the other button is low, so a chord never steps
    assign rise_up = btn_up & ~prev_up & ~btn_dn;
    assign rise_dn = btn_dn & ~prev_dn & ~btn_up;
    assign held    = dir_up ? (btn_up & ~btn_dn) : (btn_dn & ~btn_up);

    always_comb begin
        fire    = 1'b0;
        step_up = 1'b0;
        step_dn = 1'b0;
        case (state)
            IDLE: begin
                step_up = rise_up;
                step_dn = rise_dn;
            end
            HOLD: begin
                fire    = held && (timer == HOLD_LAST);
                step_up = fire & dir_up;
                step_dn = fire & ~dir_up;
            end
            REPEAT: begin
                fire    = held && (timer == REPEAT_LAST);
                step_up = fire & dir_up;
                step_dn = fire & ~dir_up;
            end
            default: ;
        endcase
        if (reset || clear) begin
            step_up = 1'b0;
            step_dn = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // Sampled through reset too, so a button held across reset is not seen as a new press
        prev_up <= btn_up;
        prev_dn <= btn_dn;
        if (reset || clear) begin
            state   <= IDLE;
            timer   <= '0;
            dir_up  <= 1'b0;
            editing <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise_up || rise_dn) begin
                        state   <= HOLD;
                        dir_up  <= rise_up;
                        timer   <= '0;
                        editing <= 1'b1;
                    end
                end
                HOLD, REPEAT: begin
                    if (!held) begin
                        state   <= IDLE;
                        timer   <= '0;
                        editing <= 1'b0;
                    end else if (fire) begin
                        state <= REPEAT;
                        timer <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    timer   <= '0;
                    editing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/time_field_counter.sv
// Purpose: one wrap-around clock/calendar field, ticked by the timebase and adjusted by buttons.
// Latency: count, carry and load_err register on the edge that sees the event.
// Backpressure: none; priority reset > load > button step > tick, losers in a cycle are dropped.
module time_field_counter
    import clock_pkg::*;
#(
    parameter int MIN_VALUE     = 0,
    parameter int MAX_VALUE     = HOURS_MAX,
    parameter int WIDTH         = 5,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             boton_aumenta,
    input  logic             boton_disminuye,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             load_err,
    output logic             editing
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VALUE);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

    logic             step_up;
    logic             step_dn;
    logic             load_ok;
    logic             at_max;
    logic             at_min;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;
    logic             tick_ok;

    button_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_btn (
        .clk     (clk),
        .reset   (reset),
        .btn_up  (boton_aumenta),
        .btn_dn  (boton_disminuye),
        .clear   (load),
        .step_up (step_up),
        .step_dn (step_dn),
        .editing (editing)
    );

    assign load_ok   = in_range(int'(load_value), MIN_VALUE, MAX_VALUE);
    assign at_max    = (count == MAX_V);
    assign at_min    = (count == MIN_V);
    assign count_inc = at_max ? MIN_V : count + WIDTH'(1);
    assign count_dec = at_min ? MAX_V : count - WIDTH'(1);
    // Time is frozen while a button is held so adjustment is not fought by the timebase
    assign tick_ok   = tick & ~editing;

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= MIN_V;
            carry    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            carry    <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    count <= load_value;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (step_up) begin
                count <= count_inc;
            end else if (step_dn) begin
                count <= count_dec;
            end else if (tick_ok) begin
                count <= count_inc;
                carry <= at_max;
            end
        end
    end

endmodule

// File: tb/tb_time_field_counter.sv
// Hours (0..23) and day (1..31) instances share stimulus; a hold-length model predicts both.
module tb_time_field_counter;
    import clock_pkg::*;

    localparam int W = 5;
    localparam int H = 4;
    localparam int R = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1, tick = 1'b0, up = 1'b0, dn = 1'b0, load = 1'b0;
    logic [W-1:0] lv = '0;
    logic [W-1:0] cnt0, cnt1;
    logic         carry0, carry1, err0, err1, ed0, ed1;

    int checks = 0;
    int errors = 0;

    time_field_counter #(.MIN_VALUE(0), .MAX_VALUE(HOURS_MAX), .WIDTH(W),
                         .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
        .clk(clk), .reset(reset), .tick(tick), .boton_aumenta(up), .boton_disminuye(dn),
        .load(load), .load_value(lv), .count(cnt0), .carry(carry0), .load_err(err0),
        .editing(ed0));

    time_field_counter #(.MIN_VALUE(DAY_MIN), .MAX_VALUE(DAY_MAX), .WIDTH(W),
                         .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut_day (
        .clk(clk), .reset(reset), .tick(tick), .boton_aumenta(up), .boton_disminuye(dn),
        .load(load), .load_value(lv), .count(cnt1), .carry(carry1), .load_err(err1),
        .editing(ed1));

    // Reference model: tracks how long a single button has been held
    int m_min[2] = '{0, DAY_MIN};
    int m_max[2] = '{HOURS_MAX, DAY_MAX};
    int m_count[2];
    int m_dir[2];
    int m_len[2];
    int m_carry[2];
    int m_err[2];
    bit m_pu = 1'b0, m_pd = 1'b0;

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int dir_pre = m_dir[i];
            int step = 0;
            m_carry[i] = 0;
            m_err[i] = 0;
            if (reset) begin
                m_count[i] = m_min[i];
                m_dir[i] = 0;
                m_len[i] = 0;
            end else if (load) begin
                if (int'(lv) >= m_min[i] && int'(lv) <= m_max[i]) m_count[i] = int'(lv);
                else m_err[i] = 1;
                m_dir[i] = 0;
            end else begin
                if (up && dn) begin
                    m_dir[i] = 0;
                end else if (m_dir[i] != 0) begin
                    if ((m_dir[i] > 0) ? up : dn) begin
                        m_len[i]++;
                        if (m_len[i] >= H && (m_len[i] - H) % R == 0) step = m_dir[i];
                    end else begin
                        m_dir[i] = 0;
                    end
                end else if (up && !m_pu) begin
                    step = 1; m_dir[i] = 1; m_len[i] = 0;
                end else if (dn && !m_pd) begin
                    step = -1; m_dir[i] = -1; m_len[i] = 0;
                end
                if (step == 1) begin
                    m_count[i] = (m_count[i] == m_max[i]) ? m_min[i] : m_count[i] + 1;
                end else if (step == -1) begin
                    m_count[i] = (m_count[i] == m_min[i]) ? m_max[i] : m_count[i] - 1;
                end else if (tick && dir_pre == 0) begin
                    if (m_count[i] == m_max[i]) begin
                        m_count[i] = m_min[i];
                        m_carry[i] = 1;
                    end else begin
                        m_count[i]++;
                    end
                end
            end
        end
        m_pu = up;
        m_pd = dn;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_models(input string tag);
        check({tag, "_h_count"}, int'(cnt0), m_count[0]);
        check({tag, "_h_carry"}, int'(carry0), m_carry[0]);
        check({tag, "_h_err"}, int'(err0), m_err[0]);
        check({tag, "_h_edit"}, int'(ed0), int'(m_dir[0] != 0));
        check({tag, "_d_count"}, int'(cnt1), m_count[1]);
        check({tag, "_d_carry"}, int'(carry1), m_carry[1]);
        check({tag, "_d_err"}, int'(err1), m_err[1]);
        check({tag, "_d_edit"}, int'(ed1), int'(m_dir[1] != 0));
    endtask

    // Drive one cycle of inputs, advance DUTs and model, sample 1 time unit after the edge
    task automatic cycle(input bit r, input bit t, input bit u, input bit d, input bit l,
                         input int v, input string tag);
        reset = r; tick = t; up = u; dn = d; load = l; lv = v[W-1:0];
        @(posedge clk);
        model_step();
        #1;
        compare_models(tag);
    endtask

    typedef struct {
        bit rst, tk, u, d, ld;
        int lv;
        int c;
        bit cy, er, ed;
    } vec_t;
    vec_t tv[$];

    function automatic void add(bit rst, bit tk, bit u, bit d, bit ld, int v,
                                int c, bit cy, bit er, bit ed);
        vec_t x;
        x.rst = rst; x.tk = tk; x.u = u; x.d = d; x.ld = ld; x.lv = v;
        x.c = c; x.cy = cy; x.er = er; x.ed = ed;
        tv.push_back(x);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit ru, rd;

        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 24; k++) add(0, 1, 0, 0, 0, 0, k % 24, k == 24, 0, 0);
        add(0, 0, 0, 1, 0, 0, 23, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 23, 0, 0, 0);
        add(0, 0, 0, 0, 1, 5, 5, 0, 0, 0);
        for (int k = 0; k < 10; k++)
            add(0, 0, 1, 0, 0, 0, 6 + int'(k >= 4) + int'(k >= 6) + int'(k >= 8), 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 9, 0, 0, 0);
        add(0, 0, 0, 0, 1, 30, 9, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 9, 0, 0, 0);
        add(0, 0, 0, 0, 1, 12, 12, 0, 0, 0);
        add(0, 1, 1, 0, 1, 3, 3, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 3, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 4, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 4, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 4, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 5, 0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < tv.size(); i++) begin
            cycle(tv[i].rst, tv[i].tk, tv[i].u, tv[i].d, tv[i].ld, tv[i].lv,
                  $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_count", i), int'(cnt0), tv[i].c);
            check($sformatf("tbl%0d_carry", i), int'(carry0), int'(tv[i].cy));
            check($sformatf("tbl%0d_err", i), int'(err0), int'(tv[i].er));
            check($sformatf("tbl%0d_edit", i), int'(ed0), int'(tv[i].ed));
        end

        // Day field: wrap below 1, reach REPEAT, then reset while the button is still held
        cycle(1, 0, 0, 0, 0, 0, "day_rst");
        check("day_rst_count", int'(cnt1), 1);
        cycle(0, 0, 0, 1, 0, 0, "day_dn");
        check("day_dn_count", int'(cnt1), 31);
        check("day_dn_carry", int'(carry1), 0);
        check("day_dn_edit", int'(ed1), 1);
        cycle(0, 0, 0, 0, 0, 0, "day_rel");
        check("day_rel_edit", int'(ed1), 0);
        cycle(0, 0, 1, 0, 0, 0, "day_up");
        check("day_up_wrap", int'(cnt1), 1);
        check("day_up_carry", int'(carry1), 0);
        for (int k = 1; k <= 5; k++) cycle(0, 0, 1, 0, 0, 0, "day_hold");
        check("day_repeat_count", int'(cnt1), 2);
        check("day_repeat_edit", int'(ed1), 1);
        cycle(1, 0, 1, 0, 0, 0, "day_rst_rep");
        check("day_rst_rep_count", int'(cnt1), 1);
        check("day_rst_rep_edit", int'(ed1), 0);
        cycle(0, 0, 1, 0, 0, 0, "day_after");
        check("day_after_count", int'(cnt1), 1);
        check("day_after_edit", int'(ed1), 0);
        cycle(0, 0, 0, 0, 0, 0, "day_idle");

        ru = 1'b0;
        rd = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) ru = ~ru;
            if ($urandom_range(0, 9) == 0) rd = ~rd;
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, ru, rd,
                  $urandom_range(0, 24) == 0, int'($urandom_range(0, 31)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
